// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared constants for the VIP flow-control stages.
package alt_vipvfr131_common_pkg;

  // Entries in the input skid FIFO.
  localparam int unsigned FifoDepth = 2;

  // Control sequencer states.
  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPending = 1'b1;

endpackage

// File: rtl/alt_vipvfr131_common_skid_fifo.sv
// Two-entry FIFO that decouples the upstream ready from the downstream read.
module alt_vipvfr131_common_skid_fifo
  import alt_vipvfr131_common_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [1:0] FullCount = 2'(FifoDepth);

  logic [Width-1:0] mem0_q, mem1_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = rd_ptr_q ? mem1_q : mem0_q;

  // Over/underflow requests are dropped rather than corrupting the store.
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) begin
        if (wr_ptr_q) mem1_q <= data_i;
        else          mem0_q <= data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_en) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_flow_control_input.sv
// Avalon-ST ready/valid to VIP stall/read adapter with control-packet sequencing.
module alt_vipvfr131_common_flow_control_input
  import alt_vipvfr131_common_pkg::*;
#(
  parameter int unsigned BITS_PER_SYMBOL    = 8,
  parameter int unsigned SYMBOLS_PER_BEAT   = 3,
  parameter logic [15:0] WIDTH_DEFAULT      = 16'd640,
  parameter logic [15:0] HEIGHT_DEFAULT     = 16'd480,
  parameter logic [3:0]  INTERLACED_DEFAULT = 4'd0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        din_valid,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  output logic                                        din_ready,
  input  logic                                        decoder_end_of_video,
  input  logic [15:0]                                 decoder_width,
  input  logic [15:0]                                 decoder_height,
  input  logic [3:0]                                  decoder_interlaced,
  input  logic                                        decoder_vip_ctrl_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  output logic                                        end_of_video_in,
  output logic [15:0]                                 width_in,
  output logic [15:0]                                 height_in,
  output logic [3:0]                                  interlaced_in,
  output logic                                        vip_ctrl_valid_in,
  input  logic                                        read,
  output logic                                        stall_in
);

  localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  logic          fifo_full, fifo_empty, push;
  logic [DW:0]   fifo_rdata;

  logic [0:0]    state_q, state_d;
  logic          rdy_en_q;
  logic [15:0]   pend_w_q, pend_w_d, pend_h_q, pend_h_d;
  logic [3:0]    pend_i_q, pend_i_d;
  logic [15:0]   width_q, width_d, height_q, height_d;
  logic [3:0]    interl_q, interl_d;
  logic          vcv_q, vcv_d;

  // Registers only: no combinational path from read to din_ready.
  assign din_ready = rdy_en_q & ~fifo_full & (state_q == StIdle);
  assign push      = din_valid & din_ready;

  alt_vipvfr131_common_skid_fifo #(
    .Width (DW + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  ({decoder_end_of_video, din_data}),
    .pop_i   (read),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign stall_in          = fifo_empty;
  assign data_in           = fifo_rdata[DW-1:0];
  assign end_of_video_in   = fifo_rdata[DW];
  assign width_in          = width_q;
  assign height_in         = height_q;
  assign interlaced_in     = interl_q;
  assign vip_ctrl_valid_in = vcv_q;

  // Control sequencer: hold new fields until the previous frame has drained.
  always_comb begin
    state_d  = state_q;
    pend_w_d = pend_w_q;
    pend_h_d = pend_h_q;
    pend_i_d = pend_i_q;
    width_d  = width_q;
    height_d = height_q;
    interl_d = interl_q;
    vcv_d    = 1'b0;
    if (decoder_vip_ctrl_valid) begin
      pend_w_d = decoder_width;
      pend_h_d = decoder_height;
      pend_i_d = decoder_interlaced;
    end
    unique case (state_q)
      StIdle: begin
        if (decoder_vip_ctrl_valid) state_d = StPending;
      end
      StPending: begin
        if (fifo_empty) begin
          // Fields arriving on the release cycle still win.
          width_d  = pend_w_d;
          height_d = pend_h_d;
          interl_d = pend_i_d;
          vcv_d    = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, pending/current fields and ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rdy_en_q <= 1'b0;
      pend_w_q <= WIDTH_DEFAULT;
      pend_h_q <= HEIGHT_DEFAULT;
      pend_i_q <= INTERLACED_DEFAULT;
      width_q  <= WIDTH_DEFAULT;
      height_q <= HEIGHT_DEFAULT;
      interl_q <= INTERLACED_DEFAULT;
      vcv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      pend_w_q <= pend_w_d;
      pend_h_q <= pend_h_d;
      pend_i_q <= pend_i_d;
      width_q  <= width_d;
      height_q <= height_d;
      interl_q <= interl_d;
      vcv_q    <= vcv_d;
    end
  end

endmodule

// File: tb/tb_alt_vipvfr131_common_flow_control_input.sv
// Scoreboard bench for the VIP flow-control input stage.
module tb_alt_vipvfr131_common_flow_control_input;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic          din_ready;
  logic          decoder_end_of_video = 1'b0;
  logic [15:0]   decoder_width = '0;
  logic [15:0]   decoder_height = '0;
  logic [3:0]    decoder_interlaced = '0;
  logic          decoder_vip_ctrl_valid = 1'b0;
  logic [DW-1:0] data_in;
  logic          end_of_video_in;
  logic [15:0]   width_in, height_in;
  logic [3:0]    interlaced_in;
  logic          vip_ctrl_valid_in;
  logic          read = 1'b0;
  logic          stall_in;

  alt_vipvfr131_common_flow_control_input dut (
    .clk                    (clk),
    .rst                    (rst),
    .din_valid              (din_valid),
    .din_data               (din_data),
    .din_ready              (din_ready),
    .decoder_end_of_video   (decoder_end_of_video),
    .decoder_width          (decoder_width),
    .decoder_height         (decoder_height),
    .decoder_interlaced     (decoder_interlaced),
    .decoder_vip_ctrl_valid (decoder_vip_ctrl_valid),
    .data_in                (data_in),
    .end_of_video_in        (end_of_video_in),
    .width_in               (width_in),
    .height_in              (height_in),
    .interlaced_in          (interlaced_in),
    .vip_ctrl_valid_in      (vip_ctrl_valid_in),
    .read                   (read),
    .stall_in               (stall_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Reference model: a queue of accepted beats plus one pending control record.
  logic [DW:0] exp_q[$];
  int          acc_total = 0, pop_total = 0, pulses = 0, pend_need = 0;
  bit          pend = 0, prev_rst = 0;
  logic [15:0] pw, ph;
  logic [3:0]  pi;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pend = 0;
      acc_total = 0;
      pop_total = 0;
    end else begin
      if (vip_ctrl_valid_in) begin
        pulses++;
        check("pulse_expected", 32'(pend), 32'd1);
        if (pend) begin
          check("pulse_after_drain", pop_total, pend_need);
          check("width_in", width_in, pw);
          check("height_in", height_in, ph);
          check("interlaced_in", interlaced_in, pi);
        end
        pend = 0;
      end
      check("stall_in", stall_in, 32'(exp_q.size() == 0));
      if (prev_rst) begin
        if (pend || exp_q.size() == 2) check("din_ready_blocked", din_ready, 0);
        else check("din_ready_open", din_ready, 1);
      end
      if (read && !stall_in) begin
        if (exp_q.size() == 0) check("pop_underflow", 1, 0);
        else check("data_in", {end_of_video_in, data_in}, exp_q.pop_front());
        pop_total++;
      end
      if (din_valid && din_ready) begin
        exp_q.push_back({decoder_end_of_video, din_data});
        acc_total++;
      end
      if (decoder_vip_ctrl_valid) begin
        pend = 1;
        pw = decoder_width;
        ph = decoder_height;
        pi = decoder_interlaced;
        pend_need = acc_total;
      end
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e);
    din_valid = 1'b1;
    din_data = d;
    decoder_end_of_video = e;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (din_ready) begin
        step();
        din_valid = 1'b0;
        decoder_end_of_video = 1'b0;
        return;
      end
      step();
    end
    check("send_timeout", 0, 1);
    din_valid = 1'b0;
  endtask

  task automatic ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
    decoder_width = w;
    decoder_height = h;
    decoder_interlaced = i;
    decoder_vip_ctrl_valid = 1'b1;
    step();
    decoder_vip_ctrl_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int start);
    for (int k = 0; k < 30; k++) begin
      if (pulses > start) return;
      step();
    end
    check("pulse_timeout", pulses, start + 1);
  endtask

  int t0, p0, n0;

  initial begin
    // Reset held: defaults and blocked input.
    #12;
    check("rst_din_ready", din_ready, 0);
    check("rst_stall", stall_in, 1);
    check("rst_width", width_in, 640);
    check("rst_height", height_in, 480);
    check("rst_interl", interlaced_in, 0);
    check("rst_vcv", vip_ctrl_valid_in, 0);
    check("rst_data", {end_of_video_in, data_in}, 0);
    @(posedge clk); #3 rst = 1'b1;
    step();
    check("rel_din_ready", din_ready, 1);
    repeat (3) step();
    check("rel_no_pulse", pulses, 0);

    // Back-to-back beats with read high: one beat per cycle.
    read = 1'b1;
    t0 = cyc;
    n0 = pop_total;
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
    check("b2b_cycles", cyc - t0, 8);
    repeat (2) step();
    check("b2b_pops", pop_total - n0, 8);

    // Read low: FIFO fills at two, then drains in order.
    read = 1'b0;
    n0 = pop_total;
    din_valid = 1'b1;
    din_data = 24'h10; step();
    din_data = 24'h11; step();
    din_data = 24'h12; step();
    @(negedge clk);
    check("full_blocks", din_ready, 0);
    step();
    read = 1'b1;
    send(24'h12, 1'b0);
    repeat (3) step();
    check("full_drain_pops", pop_total - n0, 3);

    // Frame then control packet held off by a stalled core.
    send(24'h21, 1'b0);
    send(24'h22, 1'b0);
    repeat (2) step();
    read = 1'b0;
    send(24'h23, 1'b0);
    send(24'h24, 1'b1);
    p0 = pulses;
    ctrl(16'd1920, 16'd1080, 4'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("ctrl_hold_ready", din_ready, 0);
      step();
    end
    check("ctrl_hold_no_pulse", pulses, p0);
    read = 1'b1;
    wait_pulse(p0);
    check("ctrl_width", width_in, 1920);
    check("ctrl_height", height_in, 1080);
    check("ctrl_interl", interlaced_in, 3);

    // Two control packets while pending: last one wins, single pulse.
    read = 1'b0;
    send(24'h31, 1'b1);
    p0 = pulses;
    ctrl(16'd800, 16'd600, 4'd1);
    ctrl(16'd1280, 16'd720, 4'd2);
    step();
    read = 1'b1;
    wait_pulse(p0);
    repeat (5) step();
    check("lastwins_pulses", pulses, p0 + 1);
    check("lastwins_width", width_in, 1280);
    check("lastwins_height", height_in, 720);

    // Asynchronous reset with beats buffered and a control packet pending.
    read = 1'b0;
    send(24'h41, 1'b0);
    send(24'h42, 1'b0);
    ctrl(16'd1024, 16'd768, 4'd5);
    step();
    p0 = pulses;
    #2 rst = 1'b0;
    #1;
    check("arst_width", width_in, 640);
    check("arst_height", height_in, 480);
    check("arst_interl", interlaced_in, 0);
    check("arst_stall", stall_in, 1);
    check("arst_ready", din_ready, 0);
    check("arst_data", {end_of_video_in, data_in}, 0);
    step(); step();
    @(posedge clk); #3 rst = 1'b1;
    read = 1'b1;
    repeat (10) step();
    check("arst_no_pulse", pulses, p0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      din_valid = ($urandom % 4) != 0;
      din_data = DW'($urandom);
      decoder_end_of_video = ($urandom % 8) == 0;
      decoder_vip_ctrl_valid = ($urandom % 40) == 0;
      decoder_width = 16'($urandom);
      decoder_height = 16'($urandom);
      decoder_interlaced = 4'($urandom);
      read = ($urandom % 3) != 0;
      step();
    end
    din_valid = 1'b0;
    decoder_vip_ctrl_valid = 1'b0;
    read = 1'b1;
    repeat (20) step();
    check("end_queue_empty", exp_q.size(), 0);
    check("end_no_pending", 32'(pend), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
